// File: rtl/instruction_memory_writer.sv
// Instruction memory writer: packs R-type fields into a big-endian MIPS word
// and streams it into a byte-addressed memory array one byte per cycle.
module instruction_memory_writer #(
    parameter  int size_word = 2,
    localparam int AW        = $clog2(size_word * 4),
    localparam int CW        = $clog2(size_word + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set_base,
    input  logic [AW-1:0] base_addr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [5:0]    op,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    input  logic [4:0]    shamt,
    input  logic [5:0]    func,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          busy,
    output logic          full,
    output logic [CW-1:0] word_count
);

    localparam int MEM_BYTES = size_word * 4;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    bi_q, bi_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [31:0]   word_q, word_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;
    logic [AW-1:0] base_aligned;

    // Big-endian packing of the R-type fields.
    function automatic logic [31:0] pack_word(
        input logic [5:0] f_op, input logic [4:0] f_rs, input logic [4:0] f_rt,
        input logic [4:0] f_rd, input logic [4:0] f_sh, input logic [5:0] f_fn);
        return {f_op, f_rs, f_rt, f_rd, f_sh, f_fn};
    endfunction

    // Byte 0 is the most significant byte of the word.
    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    // Advance the write pointer by one word, wrapping at the end of the array.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        if (int'(p) + 4 >= MEM_BYTES) return '0;
        return p + AW'(4);
    endfunction

    // Word alignment of the new base pointer: low two address bits dropped.
    assign base_aligned = base_addr & ~AW'(3);

    // Acceptance is blocked while a word is in flight, when full, or while rebasing.
    assign in_ready = (state_q == IDLE) && !full_q && !set_base;

    // Next-state logic; memory outputs are precomputed so they come straight from flops.
    always_comb begin
        state_d  = state_q;
        bi_d     = bi_q;
        ptr_d    = ptr_q;
        word_d   = word_q;
        count_d  = count_q;
        full_d   = full_q;

        if (set_base) begin
            state_d = IDLE;
            bi_d    = 2'd0;
            ptr_d   = base_aligned;
            count_d = '0;
            full_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state_d = WRITE;
                        bi_d    = 2'd0;
                        word_d  = pack_word(op, rs, rt, rd, shamt, func);
                    end
                end
                WRITE: begin
                    if (bi_q == 2'd3) begin
                        state_d = IDLE;
                        bi_d    = 2'd0;
                        ptr_d   = next_ptr(ptr_q);
                        count_d = count_q + CW'(1);
                        full_d  = (count_q + CW'(1) == CW'(size_word));
                    end else begin
                        bi_d = bi_q + 2'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        mem_we_d    = (state_d == WRITE);
        mem_addr_d  = mem_we_d ? ptr_d + AW'(bi_d) : '0;
        mem_wdata_d = mem_we_d ? byte_of(word_d, bi_d) : 8'h00;
    end

    // Control and memory-port registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bi_q        <= 2'd0;
            ptr_q       <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            bi_q        <= bi_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Latched instruction word; only read while a write sequence is active.
    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = (state_q == WRITE);
    assign full       = full_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_instruction_memory_writer.sv
// Testbench for instruction_memory_writer (size_word = 2, 8-byte array).
module tb_instruction_memory_writer;

    localparam int SW = 2;
    localparam int AW = 3;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          set_base;
    logic [AW-1:0] base_addr;
    logic          in_valid;
    logic          in_ready;
    logic [5:0]    op;
    logic [4:0]    rs, rt, rd, shamt;
    logic [5:0]    func;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          busy;
    logic          full;
    logic [CW-1:0] word_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_ptr;
    int          m_count;
    bit          m_full;
    logic [7:0]  exp_mem [8];
    bit          exp_set [8];
    logic [7:0]  dut_mem [8];

    instruction_memory_writer #(.size_word(SW)) dut (
        .clk(clk), .reset(reset), .set_base(set_base), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .full(full), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Memory array driven by the DUT's write port
    always @(posedge clk) begin
        if (mem_we === 1'b1) dut_mem[mem_addr] <= mem_wdata;
    end

    function automatic logic [31:0] pack_fields(
        input logic [5:0] f_op, input logic [4:0] f_rs, input logic [4:0] f_rt,
        input logic [4:0] f_rd, input logic [4:0] f_sh, input logic [5:0] f_fn);
        return {f_op, f_rs, f_rt, f_rd, f_sh, f_fn};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_fields();
        op = 6'($urandom); rs = 5'($urandom); rt = 5'($urandom);
        rd = 5'($urandom); shamt = 5'($urandom); func = 6'($urandom);
    endtask

    task automatic model_rebase(input int b);
        m_ptr = b & ~3; m_count = 0; m_full = 0;
    endtask

    task automatic write_word(input logic [5:0] f_op, input logic [4:0] f_rs,
                              input logic [4:0] f_rt, input logic [4:0] f_rd,
                              input logic [4:0] f_sh, input logic [5:0] f_fn,
                              input logic [31:0] exp_word, input string tag);
        op = f_op; rs = f_rs; rt = f_rt; rd = f_rd; shamt = f_sh; func = f_fn;
        in_valid = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready: in_ready=%b required 1", tag, in_ready);
        end
        tick();
        in_valid = 1'b0;
        scramble_fields();
        for (int i = 0; i < 4; i++) begin
            logic [AW-1:0] ea;
            logic [7:0]    eb;
            ea = AW'(m_ptr + i);
            eb = exp_word[31-8*i -: 8];
            n_checks++;
            if ({mem_we, busy, mem_addr, mem_wdata} !== {1'b1, 1'b1, ea, eb}) begin
                n_fail++;
                $display("FAIL %s_byte%0d: we=%b busy=%b addr=%0d data=%h required we=1 busy=1 addr=%0d data=%h",
                         tag, i, mem_we, busy, mem_addr, mem_wdata, ea, eb);
            end
            exp_mem[ea] = eb;
            exp_set[ea] = 1'b1;
            tick();
        end
        m_ptr   = (m_ptr + 4) % (SW * 4);
        m_count = m_count + 1;
        m_full  = (m_count == SW);
        n_checks++;
        if ({mem_we, busy, word_count, full, in_ready} !== {2'b00, CW'(m_count), m_full, !m_full}) begin
            n_fail++;
            $display("FAIL %s_done: we=%b busy=%b count=%0d full=%b ready=%b required we=0 busy=0 count=%0d full=%b ready=%b",
                     tag, mem_we, busy, word_count, full, in_ready, m_count, m_full, !m_full);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; set_base = 1'b0; base_addr = '0; in_valid = 1'b0;
        scramble_fields();
        tick(); tick();
        reset = 1'b0;
        #1;
        model_rebase(0);
        n_checks++;
        if ({in_ready, busy, mem_we, mem_addr, mem_wdata, word_count, full} !==
            {1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b busy=%b we=%b addr=%0d data=%h count=%0d full=%b required 1 0 0 0 00 0 0",
                     in_ready, busy, mem_we, mem_addr, mem_wdata, word_count, full);
        end
    endtask

    task automatic test_add();
        write_word(6'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 32'h012A4020, "add");
    endtask

    task automatic test_sll_full();
        write_word(6'd0, 5'd0, 5'd9, 5'd8, 5'd31, 6'd0, 32'h000947C0, "sll");
        in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            scramble_fields();
            #1;
            n_checks++;
            if ({mem_we, busy, in_ready, word_count, full} !== {3'b000, 2'd2, 1'b1}) begin
                n_fail++;
                $display("FAIL full_ignore%0d: we=%b busy=%b ready=%b count=%0d full=%b required 0 0 0 2 1",
                         c, mem_we, busy, in_ready, word_count, full);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_set_base_full();
        set_base = 1'b1; base_addr = 3'd5;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rebase_ready_low: in_ready=%b required 0", in_ready);
        end
        tick();
        set_base = 1'b0;
        model_rebase(5);
        #1;
        n_checks++;
        if ({full, word_count, in_ready, mem_we} !== {1'b0, 2'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL rebase_clear: full=%b count=%0d ready=%b we=%b required 0 0 1 0",
                     full, word_count, in_ready, mem_we);
        end
        scramble_fields();
        write_word(op, rs, rt, rd, shamt, func, pack_fields(op, rs, rt, rd, shamt, func), "rebase_w0");
        scramble_fields();
        write_word(op, rs, rt, rd, shamt, func, pack_fields(op, rs, rt, rd, shamt, func), "wrap_w1");
    endtask

    task automatic start_partial(output logic [31:0] w);
        scramble_fields();
        w = pack_fields(op, rs, rt, rd, shamt, func);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        scramble_fields();
        for (int i = 0; i < 2; i++) begin
            logic [AW-1:0] ea;
            ea = AW'(m_ptr + i);
            n_checks++;
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, ea, w[31-8*i -: 8]}) begin
                n_fail++;
                $display("FAIL partial_byte%0d: we=%b addr=%0d data=%h required we=1 addr=%0d data=%h",
                         i, mem_we, mem_addr, mem_wdata, ea, w[31-8*i -: 8]);
            end
            exp_mem[ea] = w[31-8*i -: 8];
            exp_set[ea] = 1'b1;
            if (i == 0) tick();
        end
    endtask

    task automatic test_abort_set_base();
        logic [31:0] w;
        set_base = 1'b1; base_addr = 3'd0;
        tick();
        set_base = 1'b0;
        model_rebase(0);
        start_partial(w);
        set_base = 1'b1; base_addr = 3'd0;
        tick();
        set_base = 1'b0;
        model_rebase(0);
        #1;
        n_checks++;
        if ({mem_we, busy, word_count, full, in_ready} !== {1'b0, 1'b0, 2'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL abort_state: we=%b busy=%b count=%0d full=%b ready=%b required 0 0 0 0 1",
                     mem_we, busy, word_count, full, in_ready);
        end
        tick();
        n_checks++;
        if (mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_tail: we=%b required 0", mem_we);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        start_partial(w);
        reset = 1'b1; set_base = 1'b1; base_addr = 3'd4;
        tick();
        reset = 1'b0; set_base = 1'b0;
        model_rebase(0);
        #1;
        n_checks++;
        if ({in_ready, busy, mem_we, mem_addr, mem_wdata, word_count, full} !==
            {1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: ready=%b busy=%b we=%b addr=%0d data=%h count=%0d full=%b required 1 0 0 0 00 0 0",
                     in_ready, busy, mem_we, mem_addr, mem_wdata, word_count, full);
        end
        scramble_fields();
        write_word(op, rs, rt, rd, shamt, func, pack_fields(op, rs, rt, rd, shamt, func), "after_reset");
    endtask

    task automatic test_set_base_with_valid();
        logic [5:0] h_op, h_fn;
        logic [4:0] h_rs, h_rt, h_rd, h_sh;
        scramble_fields();
        h_op = op; h_rs = rs; h_rt = rt; h_rd = rd; h_sh = shamt; h_fn = func;
        set_base = 1'b1; base_addr = 3'd6; in_valid = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_valid_ready: in_ready=%b required 0", in_ready);
        end
        tick();
        set_base = 1'b0;
        model_rebase(6);
        n_checks++;
        if ({mem_we, busy, word_count} !== {1'b0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL sb_valid_no_accept: we=%b busy=%b count=%0d required 0 0 0",
                     mem_we, busy, word_count);
        end
        write_word(h_op, h_rs, h_rt, h_rd, h_sh, h_fn,
                   pack_fields(h_op, h_rs, h_rt, h_rd, h_sh, h_fn), "sb_valid_held");
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            int gap;
            if (m_full) begin
                int b;
                b = int'($urandom_range(0, 7));
                set_base = 1'b1; base_addr = AW'(b);
                tick();
                set_base = 1'b0;
                model_rebase(b);
            end
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                scramble_fields();
                n_checks++;
                if (mem_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_gap%0d: we=%b required 0", k, mem_we);
                end
                tick();
            end
            scramble_fields();
            write_word(op, rs, rt, rd, shamt, func, pack_fields(op, rs, rt, rd, shamt, func), "rand");
        end
    endtask

    task automatic test_memory_image();
        tick();
        for (int a = 0; a < SW * 4; a++) begin
            if (exp_set[a]) begin
                n_checks++;
                if (dut_mem[a] !== exp_mem[a]) begin
                    n_fail++;
                    $display("FAIL mem_image[%0d]: got %h required %h", a, dut_mem[a], exp_mem[a]);
                end
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 8; a++) exp_set[a] = 1'b0;
        test_reset();
        test_add();
        test_sll_full();
        test_set_base_full();
        test_abort_set_base();
        test_reset_mid();
        test_set_base_with_valid();
        test_random();
        test_memory_image();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
